sobel_edge_3x3: RTL

- Downstream consumer of the 3x3 window generator; one Sobel edge-detection stage in the camera image path.
- Takes the nine 16-bit window pixels plus the window's vsync/hsync/clken and computes |Gx|+|Gy| on the low PIX_W bits of each pixel.
- Compares the magnitude against a runtime threshold and emits a binary edge pixel, with the sync signals delayed by the same fixed pipeline depth.
- Feeds the later binary/morphology and ball-locating stages.

---
 rtl/sobel_edge_3x3.sv | 259 +++++++++++++++++++++++++
 1 files changed

// File: rtl/sobel_edge_3x3.sv
// sobel_edge_3x3: 3x3 Sobel edge stage, |Gx|+|Gy| vs. threshold, 4-cycle latency.
// Ports: clk, rst_n (async, active-low); matrix_frame_vsync/hsync/clken and
//   matrix_11..matrix_33 (16b window, row 1 oldest, col 3 newest); threshold
//   (PIX_W+3); post_frame_vsync/hsync/clken (4-cycle delayed syncs),
//   post_img_bit (edge flag), post_img_data (16'hFFFF on edge, else 0).
// Optional: define SOBEL_BORDER_MASK_EN to suppress edges on the outer
//   row/column ring of an IMG_W x IMG_H frame.

module sobel_edge_3x3 #(
    parameter int PIX_W = 8,
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             matrix_frame_vsync,
    input  logic             matrix_frame_hsync,
    input  logic             matrix_frame_clken,
    input  logic [15:0]      matrix_11,
    input  logic [15:0]      matrix_12,
    input  logic [15:0]      matrix_13,
    input  logic [15:0]      matrix_21,
    input  logic [15:0]      matrix_22,
    input  logic [15:0]      matrix_23,
    input  logic [15:0]      matrix_31,
    input  logic [15:0]      matrix_32,
    input  logic [15:0]      matrix_33,
    input  logic [PIX_W+2:0] threshold,
    output logic             post_frame_vsync,
    output logic             post_frame_hsync,
    output logic             post_frame_clken,
    output logic             post_img_bit,
    output logic [15:0]      post_img_data
);

    localparam int SW = PIX_W + 2;
    localparam int MW = PIX_W + 3;

    // ------------------------------------------------------------
    // Pixel extraction: only the luma bits take part.
    // ------------------------------------------------------------
    logic [PIX_W-1:0] p11, p12, p13;
    logic [PIX_W-1:0] p21, p23;
    logic [PIX_W-1:0] p31, p32, p33;

    assign p11 = matrix_11[PIX_W-1:0];
    assign p12 = matrix_12[PIX_W-1:0];
    assign p13 = matrix_13[PIX_W-1:0];
    assign p21 = matrix_21[PIX_W-1:0];
    assign p23 = matrix_23[PIX_W-1:0];
    assign p31 = matrix_31[PIX_W-1:0];
    assign p32 = matrix_32[PIX_W-1:0];
    assign p33 = matrix_33[PIX_W-1:0];

    // Centre pixel and upper pixel bits do not contribute to the kernel.
    logic unused_bits;
    assign unused_bits = ^{matrix_11[15:PIX_W], matrix_12[15:PIX_W],
                           matrix_13[15:PIX_W], matrix_21[15:PIX_W],
                           matrix_22,           matrix_23[15:PIX_W],
                           matrix_31[15:PIX_W], matrix_32[15:PIX_W],
                           matrix_33[15:PIX_W]};

    // a + 2b + c, never exceeds 4*(2^PIX_W-1) so SW bits suffice.
    function automatic logic [SW-1:0] wsum(
        input logic [PIX_W-1:0] a,
        input logic [PIX_W-1:0] b,
        input logic [PIX_W-1:0] c
    );
        return {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c};
    endfunction

    // Larger minus smaller keeps the result unsigned without wrap.
    function automatic logic [SW-1:0] absdiff(
        input logic [SW-1:0] a,
        input logic [SW-1:0] b
    );
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    // ------------------------------------------------------------
    // Stage 1: partial sums
    // ------------------------------------------------------------
    logic [SW-1:0] gx_p_d, gx_p_q;
    logic [SW-1:0] gx_n_d, gx_n_q;
    logic [SW-1:0] gy_p_d, gy_p_q;
    logic [SW-1:0] gy_n_d, gy_n_q;

    always_comb begin
        gx_p_d = wsum(p13, p23, p33);
        gx_n_d = wsum(p11, p21, p31);
        gy_p_d = wsum(p11, p12, p13);
        gy_n_d = wsum(p31, p32, p33);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gx_p_q <= '0;
            gx_n_q <= '0;
            gy_p_q <= '0;
            gy_n_q <= '0;
        end else begin
            gx_p_q <= gx_p_d;
            gx_n_q <= gx_n_d;
            gy_p_q <= gy_p_d;
            gy_n_q <= gy_n_d;
        end
    end

    // ------------------------------------------------------------
    // Stage 2: absolute differences
    // ------------------------------------------------------------
    logic [SW-1:0] ax_d, ax_q;
    logic [SW-1:0] ay_d, ay_q;

    always_comb begin
        ax_d = absdiff(gx_p_q, gx_n_q);
        ay_d = absdiff(gy_p_q, gy_n_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ax_q <= '0;
            ay_q <= '0;
        end else begin
            ax_q <= ax_d;
            ay_q <= ay_d;
        end
    end

    // ------------------------------------------------------------
    // Stage 3: magnitude, one extra bit so the sum cannot overflow
    // ------------------------------------------------------------
    logic [MW-1:0] mag_d, mag_q;

    assign mag_d = {1'b0, ax_q} + {1'b0, ay_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mag_q <= '0;
        end else begin
            mag_q <= mag_d;
        end
    end

    // ------------------------------------------------------------
    // Sync delay lines; tap [2] lines up with stage 3, tap [3] with
    // the registered result.
    // ------------------------------------------------------------
    logic [3:0] vs_d, vs_q;
    logic [3:0] hs_d, hs_q;
    logic [3:0] ck_d, ck_q;

    always_comb begin
        vs_d = {vs_q[2:0], matrix_frame_vsync};
        hs_d = {hs_q[2:0], matrix_frame_hsync};
        ck_d = {ck_q[2:0], matrix_frame_clken};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_q <= '0;
            hs_q <= '0;
            ck_q <= '0;
        end else begin
            vs_q <= vs_d;
            hs_q <= hs_d;
            ck_q <= ck_d;
        end
    end

    // ------------------------------------------------------------
    // Border mask
    // ------------------------------------------------------------
    logic keep;

`ifdef SOBEL_BORDER_MASK_EN
    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    logic [CW-1:0] col_d, col_q;
    logic [RW-1:0] row_d, row_q;
    logic [2:0]    bord_d, bord_q;
    logic          border;
    logic          hs_fall;

    // hs_q[0] holds the previous input hsync.
    assign hs_fall = hs_q[0] & ~matrix_frame_hsync;

    always_comb begin
        col_d = col_q;
        if (!matrix_frame_hsync) begin
            col_d = '0;
        end else if (matrix_frame_clken && col_q != COL_LAST) begin
            col_d = col_q + CW'(1);
        end
    end

    always_comb begin
        row_d = row_q;
        if (!matrix_frame_vsync) begin
            row_d = '0;
        end else if (hs_fall && row_q != ROW_LAST) begin
            row_d = row_q + RW'(1);
        end
    end

    // Counters describe the pixel currently at the input.
    assign border = (col_q == '0) || (col_q == COL_LAST) ||
                    (row_q == '0) || (row_q == ROW_LAST);

    assign bord_d = {bord_q[1:0], border};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q  <= '0;
            row_q  <= '0;
            bord_q <= '0;
        end else begin
            col_q  <= col_d;
            row_q  <= row_d;
            bord_q <= bord_d;
        end
    end

    assign keep = ~bord_q[2];
`else
    logic unused_cfg;
    assign unused_cfg = (IMG_W > 0) ^ (IMG_H > 0);
    assign keep = 1'b1;
`endif

    // ------------------------------------------------------------
    // Stage 4: threshold compare and blanking
    // ------------------------------------------------------------
    logic        edge_d;
    logic        bit_q;
    logic [15:0] data_q;

    assign edge_d = (mag_q >= threshold) & ck_q[2] & hs_q[2] & keep;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_q  <= 1'b0;
            data_q <= '0;
        end else begin
            bit_q  <= edge_d;
            data_q <= {16{edge_d}};
        end
    end

    assign post_frame_vsync = vs_q[3];
    assign post_frame_hsync = hs_q[3];
    assign post_frame_clken = ck_q[3];
    assign post_img_bit     = bit_q;
    assign post_img_data    = data_q;

endmodule
